// File: rtl/lfsr_crypt_stream.sv
// Streaming LFSR cipher: encrypt pads ASCII text into a 64-byte parity-tagged frame,
// and decrypt turns 64 received cipher bytes back into ASCII.
module lfsr_crypt_stream #(
  parameter int FRAME_LEN = 64,
  parameter int MAX_TEXT  = 52,
  parameter int LFSR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [3:0]        pre_len,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [5:0]        out_idx,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              ack
);

  localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);
  localparam logic [5:0] TEXT_LAST = 6'(MAX_TEXT - 1);
  localparam logic [3:0] PRE_MIN   = 4'd10;

  typedef enum logic [2:0] {IDLE, PRE, MSG, POST, DEC, DRAIN, DONE} state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] taps_q;
  logic [3:0]        pre_len_q;
  logic [5:0]        idx;
  logic [5:0]        text_cnt;

  logic              load;
  logic              accept;
  logic              emit;
  logic [LFSR_W-1:0] lfsr_next;
  logic [7:0]        plain_off;
  logic [LFSR_W-1:0] enc_c;
  logic [7:0]        emit_byte;
  logic              in_parity_bad;

  // The output register is free when empty or being drained this cycle; padding
  // states emit on a free slot, MSG/DEC only when an input byte is accepted.
  always_comb begin
    load          = !out_valid || out_ready;
    in_ready      = ((state == MSG) || (state == DEC)) && load;
    accept        = in_ready && in_valid;
    emit          = (((state == PRE) || (state == POST)) && load) ||
                    (((state == MSG) || (state == DEC)) && accept);
    lfsr_next     = {lfsr[LFSR_W-2:0], ^(lfsr & taps_q)};
    plain_off     = in_data - 8'h20;
    enc_c         = (state == MSG) ? (plain_off[LFSR_W-1:0] ^ lfsr) : lfsr;
    in_parity_bad = in_data[7] != (^in_data[LFSR_W-1:0]);
    if (state == DEC) begin
      emit_byte = {1'b0, in_data[LFSR_W-1:0] ^ lfsr} + 8'h20;
    end else begin
      emit_byte = {^enc_c, enc_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= '0;
      taps_q     <= '0;
      pre_len_q  <= '0;
      idx        <= '0;
      text_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      parity_err <= 1'b0;
      ack        <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            ack        <= 1'b0;
            parity_err <= 1'b0;
            taps_q     <= taps;
            pre_len_q  <= (pre_len < PRE_MIN) ? PRE_MIN : pre_len;
            lfsr       <= (seed == '0) ? LFSR_W'(1) : seed;
            idx        <= '0;
            text_cnt   <= '0;
            state      <= mode ? DEC : PRE;
          end
        end
        PRE: begin
          if (load && (idx == ({2'b00, pre_len_q} - 6'd1))) begin
            state <= MSG;
          end
        end
        MSG: begin
          if (accept) begin
            text_cnt <= text_cnt + 6'd1;
            if (idx == LAST_IDX) begin
              state <= DRAIN;
            end else if (in_last || (text_cnt == TEXT_LAST)) begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (load && (idx == LAST_IDX)) begin
            state <= DRAIN;
          end
        end
        DEC: begin
          if (accept) begin
            parity_err <= parity_err | in_parity_bad;
            if (idx == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        // The final byte sits in the output register until the consumer takes it.
        DRAIN: begin
          if (out_ready) begin
            state <= DONE;
            ack   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_byte;
        out_idx   <= idx;
        idx       <= idx + 6'd1;
        lfsr      <= lfsr_next;
      end
    end
  end

endmodule
